sha256_msg_sched: RTL and testbench

- SHA-256 message-schedule stage directly downstream of the padded-block generator.
- Captures one 512-bit padded block on the generator's ready indication.
- Expands the block into the 64 schedule words W0..W63 using a 16-word sliding window.
- Streams the words one per accepted cycle over a valid/ready handshake to the compression-round engine.

---
 rtl/sha256_pkg.sv | 51 +++++
 rtl/sha256_sched_expand.sv | 20 ++
 rtl/sha256_msg_sched.sv | 116 +++++++++++
 tb/tb_sha256_msg_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word and block sizes, message-schedule FSM state,
// round-constant table K and the small sigma functions s0/s1. The compression
// round reuses this package.
package sha256_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned NUM_ROUNDS  = 64;
  localparam int unsigned BLOCK_WIDTH = 512;
  localparam int unsigned WIN_WORDS   = BLOCK_WIDTH / WORD_WIDTH;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } sched_state_e;

  localparam word_t K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_expand.sv
// Combinational SHA-256 schedule expansion.
// Ports:
//   tap0      W_t      (window word 0)
//   tap1      W_{t+1}  (window word 1)
//   tap9      W_{t+9}  (window word 9)
//   tap14     W_{t+14} (window word 14)
//   next_word W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t, mod 2^32
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] tap0,
  input  logic [WORD_WIDTH-1:0] tap1,
  input  logic [WORD_WIDTH-1:0] tap9,
  input  logic [WORD_WIDTH-1:0] tap14,
  output logic [WORD_WIDTH-1:0] next_word
);

  assign next_word = s1(tap14) + tap9 + s0(tap1) + tap0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: captures a 512-bit padded block, expands it into
// W0..W63 with a 16-word sliding window and streams one word per accepted
// cycle over valid/ready.
// Optional build macro SHA256_SCHED_ADD_K_EN: w_data carries W_t + K_t.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   pad_msg_rdy       padded block on pad_mem valid (level)
//   pad_mem           block, big-endian (W0 in bits 511:480)
//   w_ready           downstream accepts the current word
//   w_valid, w_data   schedule word stream
//   w_idx             round index t of w_data
//   sched_busy        high from capture until the last word is accepted
//   sched_done        one-cycle pulse after W63 is accepted
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pad_msg_rdy,
  input  logic [BLOCK_WIDTH-1:0] pad_mem,
  input  logic                   w_ready,
  output logic                   w_valid,
  output logic [WORD_WIDTH-1:0]  w_data,
  output logic [5:0]             w_idx,
  output logic                   sched_busy,
  output logic                   sched_done
);

  localparam logic [5:0] LastIdx   = 6'(NUM_ROUNDS - 1);
  // Beyond this index W_{t+16} would exceed W63, so expansion stops.
  localparam logic [5:0] LastExpIdx = 6'(NUM_ROUNDS - WIN_WORDS - 1);

  sched_state_e state_q, state_d;

  word_t      win_q [WIN_WORDS];
  logic [5:0] t_q;
  logic       armed_q;
  word_t      next_word;
  logic       accept;

  assign accept = (state_q == StRun) && w_ready;

  sha256_sched_expand u_expand (
    .tap0      (win_q[0]),
    .tap1      (win_q[1]),
    .tap9      (win_q[9]),
    .tap14     (win_q[14]),
    .next_word (next_word)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pad_msg_rdy && armed_q) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (accept && (t_q == LastIdx)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_valid    = (state_q == StRun);
    sched_busy = (state_q == StLoad) || (state_q == StRun);
    sched_done = (state_q == StDone);
    w_idx      = t_q;
    w_data     = '0;
    if (w_valid) begin
`ifdef SHA256_SCHED_ADD_K_EN
      w_data = win_q[0] + K[t_q];
`else
      w_data = win_q[0];
`endif
    end
  end

  // Window, round index and re-arm flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN_WORDS; i++) win_q[i] <= '0;
      t_q     <= '0;
      armed_q <= 1'b1;
    end else begin
      if (state_q == StLoad) begin
        for (int i = 0; i < WIN_WORDS; i++) begin
          win_q[i] <= pad_mem[BLOCK_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH];
        end
        t_q <= '0;
      end else if (accept) begin
        for (int i = 0; i < WIN_WORDS - 1; i++) win_q[i] <= win_q[i+1];
        // Words 48..63 are already in the window; the fill value is unused.
        win_q[WIN_WORDS-1] <= (t_q <= LastExpIdx) ? next_word : '0;
        if (t_q != LastIdx) t_q <= t_q + 6'd1;
      end

      // A level held high across a block must drop before it can retrigger.
      if (state_q == StLoad) begin
        armed_q <= 1'b0;
      end else if (!pad_msg_rdy) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched using the "abc" padded block.
// Expected words come from an independent schedule computation in the bench.
module tb_sha256_msg_sched;

  logic         clock = 1'b0;
  logic         reset;
  logic         pad_msg_rdy;
  logic [511:0] pad_mem;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         sched_busy;
  logic         sched_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_done   = 0;

  logic [31:0] ref_w [64];

  sha256_msg_sched dut (
    .clock       (clock),
    .reset       (reset),
    .pad_msg_rdy (pad_msg_rdy),
    .pad_mem     (pad_mem),
    .w_ready     (w_ready),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_idx       (w_idx),
    .sched_busy  (sched_busy),
    .sched_done  (sched_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (w_valid && w_ready) n_acc <= n_acc + 1;
    if (sched_done) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] exp_word(input int t);
`ifdef SHA256_SCHED_ADD_K_EN
    return ref_w[t] + sha256_pkg::K[t];
`else
    return ref_w[t];
`endif
  endfunction

  initial begin
    int acc0;
    int done0;
    int e;
    logic [31:0] a;
    logic [31:0] b;

    pad_mem = '0;
    pad_mem[511:480] = 32'h61626380;
    pad_mem[31:0]    = 32'h00000018;
    for (int i = 0; i < 16; i++) ref_w[i] = pad_mem[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = ror(ref_w[i-2], 17) ^ ror(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
      b = ror(ref_w[i-15], 7) ^ ror(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
      ref_w[i] = a + ref_w[i-7] + b + ref_w[i-16];
    end

    reset = 1'b0;
    pad_msg_rdy = 1'b0;
    w_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", 64'(w_valid), 64'd0);
    check("rst_data", 64'(w_data), 64'd0);
    check("rst_idx", 64'(w_idx), 64'd0);
    check("rst_busy", 64'(sched_busy), 64'd0);
    check("rst_done", 64'(sched_done), 64'd0);
    reset = 1'b1;
    tick();

    // Block 1, w_ready high: trigger cycle c, first valid at c+2, done at c+66
    // (67 cycles counting the trigger and done cycles).
    pad_msg_rdy = 1'b1;
    w_ready = 1'b1;
    check("idle_valid", 64'(w_valid), 64'd0);
    tick();
    check("load_valid", 64'(w_valid), 64'd0);
    check("load_busy", 64'(sched_busy), 64'd1);
    pad_msg_rdy = 1'b0;
    tick();
    for (int t = 0; t < 64; t++) begin
      check("abc_valid", 64'(w_valid), 64'd1);
      check("abc_word", {26'd0, w_idx, w_data}, {26'd0, 6'(t), exp_word(t)});
`ifdef SHA256_SCHED_ADD_K_EN
      if (t == 0) check("abc_wk0", 64'(w_data), 64'hA3EC9318);
`else
      if (t == 0)  check("abc_w0", 64'(w_data), 64'h61626380);
      if (t == 15) check("abc_w15", 64'(w_data), 64'h00000018);
      if (t == 16) check("abc_w16", 64'(w_data), 64'h61626380);
      if (t == 17) check("abc_w17", 64'(w_data), 64'h000F0000);
`endif
      tick();
    end
    check("abc_done", 64'(sched_done), 64'd1);
    check("abc_busy_end", 64'(sched_busy), 64'd0);
    check("abc_valid_end", 64'(w_valid), 64'd0);
    tick();
    check("abc_done_pulse", 64'(sched_done), 64'd0);

    // Block 2, w_ready low on even cycles, high on odd: 128 valid cycles.
    pad_msg_rdy = 1'b1;
    w_ready = 1'b0;
    tick();
    pad_msg_rdy = 1'b0;
    tick();
    e = 0;
    for (int k = 0; k < 128; k++) begin
      w_ready = k[0];
      check("stall_word", {25'd0, w_valid, w_idx, w_data}, {25'd0, 1'b1, 6'(e), exp_word(e)});
      tick();
      if (k[0]) e++;
    end
    check("stall_done", 64'(sched_done), 64'd1);
    check("stall_count", 64'(e), 64'd64);
    tick();

    // Level held high for 200 cycles yields exactly one block.
    w_ready = 1'b1;
    pad_msg_rdy = 1'b1;
    acc0 = n_acc;
    done0 = n_done;
    repeat (200) tick();
    check("hold_words", 64'(n_acc - acc0), 64'd64);
    check("hold_dones", 64'(n_done - done0), 64'd1);
    check("hold_idle", 64'(sched_busy), 64'd0);
    pad_msg_rdy = 1'b0;
    tick();
    pad_msg_rdy = 1'b1;
    acc0 = n_acc;
    done0 = n_done;
    repeat (80) tick();
    check("rearm_words", 64'(n_acc - acc0), 64'd64);
    check("rearm_dones", 64'(n_done - done0), 64'd1);

    // Reset mid-block at w_idx=20 with the level still high.
    pad_msg_rdy = 1'b0;
    tick();
    pad_msg_rdy = 1'b1;
    tick();
    tick();
    repeat (20) tick();
    check("pre_rst_idx", 64'(w_idx), 64'd20);
    done0 = n_done;
    reset = 1'b0;
    #1;
    check("abort_valid", 64'(w_valid), 64'd0);
    check("abort_idx", 64'(w_idx), 64'd0);
    check("abort_data", 64'(w_data), 64'd0);
    check("abort_busy", 64'(sched_busy), 64'd0);
    check("abort_done", 64'(sched_done), 64'd0);
    repeat (3) tick();
    check("abort_no_done", 64'(n_done), 64'(done0));
    reset = 1'b1;
    tick();
    check("restart_load", 64'(sched_busy), 64'd1);
    tick();
    check("restart_word", {25'd0, w_valid, w_idx, w_data}, {25'd0, 1'b1, 6'd0, exp_word(0)});
    pad_msg_rdy = 1'b0;
    repeat (70) tick();
    check("restart_done", 64'(n_done - done0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
